// File: rtl/nios_pio_pkg.sv
// Shared register map and STATUS layout for the NIOS PIO data-out block.
package nios_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_STATUS  = 2'd1,
        ADDR_CONTROL = 2'd2,
        ADDR_CLEAR   = 2'd3
    } reg_addr_e;

    localparam int unsigned STAT_EMPTY_BIT  = 0;
    localparam int unsigned STAT_FULL_BIT   = 1;
    localparam int unsigned STAT_OVF_BIT    = 2;
    localparam int unsigned STAT_COUNT_LSB  = 4;
    localparam int unsigned STAT_COUNT_W    = 5;

    localparam int unsigned CTRL_ENABLE_BIT = 0;

endpackage

// File: rtl/nios_sync_fifo.sv
// Single-clock FIFO with push/pop/flush; storage is not reset, only pointers.
module nios_sync_fifo #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_acc;
    logic              push_acc;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; flush beats push, a full FIFO
    // still accepts a push when the head leaves on the same cycle.
    always_comb begin
        pop_acc  = pop && !empty;
        push_acc = push && !flush && (!full || pop_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_acc && !pop_acc) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_acc && !push_acc) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (push_acc && !reset) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/nios_data_out.sv
// Avalon-MM slave feeding a valid/ready output stream through a small FIFO.
module nios_data_out
    import nios_pio_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              enable_q, enable_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] last_sent_q, last_sent_d;
    logic [31:0]       readdata_q, readdata_d;

    logic              wr_en;
    logic              data_wr;
    logic              ctrl_wr;
    logic              clear_wr;
    logic              xfer;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              unused_wdata;
    reg_addr_e         addr;

    assign unused_wdata = ^writedata;

    nios_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (data_wr),
        .push_data (writedata[DATA_W-1:0]),
        .pop       (xfer),
        .flush     (clear_wr),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = enable_q && !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_head;
    assign readdata  = readdata_q;

    // Bus decode, handshake and next-state for the control registers.
    always_comb begin
        addr        = reg_addr_e'(address);
        wr_en       = chipselect && !write_n;
        data_wr     = wr_en && (addr == ADDR_DATA);
        ctrl_wr     = wr_en && (addr == ADDR_CONTROL);
        clear_wr    = wr_en && (addr == ADDR_CLEAR);
        xfer        = out_valid && out_ready;

        enable_d    = enable_q;
        overflow_d  = overflow_q;
        last_sent_d = last_sent_q;

        if (ctrl_wr) begin
            enable_d = writedata[CTRL_ENABLE_BIT];
        end
        if (xfer) begin
            last_sent_d = fifo_head;
        end
        if (clear_wr) begin
            overflow_d = 1'b0;
        end else if (data_wr && fifo_full && !xfer) begin
            overflow_d = 1'b1;
        end

        readdata_d = '0;
        case (addr)
            ADDR_DATA: begin
                readdata_d[DATA_W-1:0] = last_sent_q;
            end
            ADDR_STATUS: begin
                readdata_d[STAT_EMPTY_BIT]             = fifo_empty;
                readdata_d[STAT_FULL_BIT]              = fifo_full;
                readdata_d[STAT_OVF_BIT]               = overflow_q;
                readdata_d[STAT_COUNT_LSB +: CNT_W]    = fifo_count;
            end
            ADDR_CONTROL: begin
                readdata_d[CTRL_ENABLE_BIT] = enable_q;
            end
            default: begin
                readdata_d = '0;
            end
        endcase
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q    <= 1'b0;
            overflow_q  <= 1'b0;
            last_sent_q <= '0;
            readdata_q  <= '0;
        end else begin
            enable_q    <= enable_d;
            overflow_q  <= overflow_d;
            last_sent_q <= last_sent_d;
            readdata_q  <= readdata_d;
        end
    end

endmodule

// File: tb/tb_nios_data_out.sv
// Self-checking bench for nios_data_out with a queue-based reference model.
module tb_nios_data_out;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [DATA_W-1:0] mq[$];
    bit                m_en;
    bit                m_ovf;
    logic [DATA_W-1:0] m_last;
    logic [31:0]       m_rd;

    always #5 clk = ~clk;

    nios_data_out #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    function automatic bit m_valid();
        return m_en && (mq.size() != 0);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit          xfer;
        bit          wr;
        int          n;
        logic [31:0] rdn;
        n    = mq.size();
        xfer = m_valid() && out_ready;
        wr   = chipselect && !write_n;
        rdn  = 32'd0;
        case (address)
            2'd0: rdn = 32'(m_last);
            2'd1: rdn = (32'(n) << 4) | (m_ovf ? 32'd4 : 32'd0) |
                        ((n == int'(DEPTH)) ? 32'd2 : 32'd0) | ((n == 0) ? 32'd1 : 32'd0);
            2'd2: rdn = m_en ? 32'd1 : 32'd0;
            default: rdn = 32'd0;
        endcase
        if (reset) begin
            mq.delete();
            m_en   = 1'b0;
            m_ovf  = 1'b0;
            m_last = '0;
            m_rd   = 32'd0;
        end else begin
            m_rd = rdn;
            if (xfer) begin
                m_last = mq.pop_front();
            end
            if (wr) begin
                case (address)
                    2'd0: begin
                        if (n < int'(DEPTH) || xfer) mq.push_back(writedata[DATA_W-1:0]);
                        else m_ovf = 1'b1;
                    end
                    2'd2: m_en = writedata[0];
                    2'd3: begin
                        mq.delete();
                        m_ovf = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] d);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b1, 2'd0, 32'd0);
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata: got %h expected 00000000", readdata); end
        drive(1'b1, 1'b1, 2'd1, 32'd0);
        tick();
        checks++;
        if (readdata !== 32'h1) begin errors++; $display("FAIL reset_status: got %h expected 00000001", readdata); end
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b0, 2'd2, 32'd1);
        tick();
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 2'd0, 32'hABC);
        tick();
        drive(1'b0, 1'b1, 2'd1, 32'd0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 12'hABC) begin
            errors++; $display("FAIL basic_out: got valid=%b data=%h expected valid=1 data=abc", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b expected 0", out_valid); end
        drive(1'b1, 1'b1, 2'd0, 32'd0);
        tick();
        checks++;
        if (readdata !== 32'h00000ABC) begin errors++; $display("FAIL basic_last: got %h expected 00000abc", readdata); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0, 2'd0, 32'(i));
            tick();
        end
        drive(1'b1, 1'b1, 2'd1, 32'd0);
        tick();
        checks++;
        if (readdata !== 32'h46) begin errors++; $display("FAIL ovf_status: got %h expected 00000046", readdata); end
        drive(1'b0, 1'b1, 2'd1, 32'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 12'(i)) begin
                errors++; $display("FAIL ovf_order%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, 12'(i));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", out_valid); end
        drive(1'b1, 1'b0, 2'd3, 32'd0);
        tick();
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        for (int i = 5; i <= 8; i++) begin
            drive(1'b1, 1'b0, 2'd0, 32'(i));
            tick();
        end
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 2'd0, 32'd9);
        checks++;
        if (out_data !== 12'h5) begin errors++; $display("FAIL fpp_head: got %h expected 005", out_data); end
        tick();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 2'd1, 32'd0);
        tick();
        checks++;
        if (readdata !== 32'h42) begin errors++; $display("FAIL fpp_status: got %h expected 00000042", readdata); end
        drive(1'b0, 1'b1, 2'd1, 32'd0);
        out_ready = 1'b1;
        for (int i = 6; i <= 9; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 12'(i)) begin
                errors++; $display("FAIL fpp_order%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, 12'(i));
            end
            tick();
        end
    endtask

    task automatic test_enable();
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 2'd2, 32'd0);
        tick();
        drive(1'b1, 1'b0, 2'd0, 32'h11);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL en_off1: got %b expected 0", out_valid); end
        drive(1'b1, 1'b0, 2'd0, 32'h22);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL en_off2: got %b expected 0", out_valid); end
        drive(1'b1, 1'b1, 2'd1, 32'd0);
        tick();
        checks++;
        if (readdata !== 32'h20) begin errors++; $display("FAIL en_status: got %h expected 00000020", readdata); end
        drive(1'b1, 1'b0, 2'd2, 32'd1);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 12'h11) begin
            errors++; $display("FAIL en_on: got valid=%b data=%h expected valid=1 data=011", out_valid, out_data);
        end
        drive(1'b0, 1'b1, 2'd1, 32'd0);
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL en_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 2'd0, 32'h31 + 32'(i));
            tick();
        end
        drive(1'b1, 1'b0, 2'd0, 32'h34);
        tick();
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF);
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b expected 0", out_valid); end
        drive(1'b1, 1'b1, 2'd1, 32'd0);
        tick();
        checks++;
        if (readdata !== 32'h1) begin errors++; $display("FAIL clr_status: got %h expected 00000001", readdata); end
        drive(1'b1, 1'b1, 2'd0, 32'd0);
        tick();
        checks++;
        if (readdata !== 32'h31) begin errors++; $display("FAIL clr_last: got %h expected 00000031", readdata); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 2'd0, 32'h51);
        tick();
        drive(1'b1, 1'b0, 2'd0, 32'h52);
        tick();
        drive(1'b0, 1'b1, 2'd0, 32'd0);
        out_ready = 1'b1;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || readdata !== 32'd0) begin
            errors++; $display("FAIL rst_mid_outs: got valid=%b data=%h rd=%h expected all 0", out_valid, out_data, readdata);
        end
        drive(1'b1, 1'b1, 2'd1, 32'd0);
        tick();
        checks++;
        if (readdata !== 32'h1) begin errors++; $display("FAIL rst_mid_status: got %h expected 00000001", readdata); end
        drive(1'b1, 1'b1, 2'd2, 32'd0);
        tick();
        checks++;
        if (readdata !== 32'h0) begin errors++; $display("FAIL rst_mid_ctrl: got %h expected 00000000", readdata); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 79) == 0);
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 2) == 0);
            address    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            writedata  = $urandom;
            if (address == 2'd2 && !write_n) writedata[0] = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            tick();
            checks++;
            if (out_valid !== m_valid()) begin
                errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", i, out_valid, m_valid());
            end
            checks++;
            if (readdata !== m_rd) begin
                errors++; $display("FAIL rnd_readdata@%0d: got %h expected %h", i, readdata, m_rd);
            end
            if (m_valid()) begin
                checks++;
                if (out_data !== mq[0]) begin
                    errors++; $display("FAIL rnd_data@%0d: got %h expected %h", i, out_data, mq[0]);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        m_en   = 1'b0;
        m_ovf  = 1'b0;
        m_last = '0;
        m_rd   = 32'd0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_enable();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
